// File: rtl/icmp_echo_tx_pkg.sv
// icmp_echo_tx_pkg: shared frame constants, FSM encoding and ones-complement fold for the ICMP echo transmitter.
package icmp_echo_tx_pkg;
   localparam int ETH_HDR_LEN = 14;
   localparam int IP_HDR_LEN = 20;
   localparam int ICMP_HDR_LEN = 8;
   localparam int HDR_LEN = ETH_HDR_LEN + IP_HDR_LEN + ICMP_HDR_LEN;
   localparam logic [15:0] IP_TYPE = 16'h0800;
   localparam logic [15:0] IP_VS_LEN_TOS = 16'h4500;
   localparam logic [7:0] ICMP_PROTO = 8'h01;
   localparam logic [7:0] ICMP_ECHO_REPLY = 8'h00;

   typedef enum logic [2:0] {IDLE, LOAD, DROP, CKS1, CKS2, TX_HDR, TX_DATA} state_t;

   function automatic logic [31:0] cks_fold(input logic [31:0] s);
      return {16'h0, s[31:16]} + {16'h0, s[15:0]};
   endfunction
endpackage

// File: rtl/icmp_payload_buf.sv
// icmp_payload_buf: simple dual-port payload RAM with one-cycle registered read.
module icmp_payload_buf #(
   parameter int DEPTH = 1472,
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);
   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/icmp_echo_tx.sv
// icmp_echo_tx: buffers an echo payload, computes IP/ICMP checksums on the fly and
// streams a complete Ethernet/IPv4/ICMP echo-reply frame with backpressure.
module icmp_echo_tx
   import icmp_echo_tx_pkg::*;
#(
   parameter logic [47:0] FPGA_MAC = 48'h00D0_0800_0002,
   parameter logic [31:0] FPGA_IP = 32'hC0A8_006E,
   parameter int MAX_PAYLOAD = 1472,
   parameter int AW = $clog2(MAX_PAYLOAD + 1)
) (
   input  logic        CLK_125M,
   input  logic        SYS_RST,
   input  logic [47:0] PC_MAC,
   input  logic [31:0] PC_IP,
   input  logic [7:0]  RX_ICMP_TDATA,
   input  logic        RX_ICMP_TVALID,
   output logic        RX_ICMP_TREADY,
   input  logic        RX_ICMP_TLAST,
   input  logic [63:0] RX_ICMP_TUSER,
   output logic [7:0]  ICMP_DATA,
   output logic        ICMP_VALID,
   input  logic        ICMP_READY,
   output logic        ICMP_LAST,
   output logic        ICMP_DROP
);
   localparam logic [AW-1:0] MAX_LEN = AW'(MAX_PAYLOAD);

   state_t state, state_n;
   logic fire, first, ovf, adv, hdr_end, data_end, ren, unused_rsvd;
   logic [AW-1:0] len, rptr, raddr;
   logic [31:0] sum32, ip_sum, ip_raw;
   logic [47:0] dst_mac;
   logic [31:0] dst_ip;
   logic [55:0] user;
   logic [335:0] hdr;
   logic [5:0] hcnt;
   logic [7:0] rdata;
   logic [15:0] total_len, icmp_cks, ip_cks;

   assign fire = RX_ICMP_TVALID && RX_ICMP_TREADY;
   assign first = len == '0;
   assign ovf = len == MAX_LEN;
   assign adv = !ICMP_VALID || ICMP_READY;
   assign hdr_end = hcnt == 6'(HDR_LEN - 1);
   assign data_end = rptr == len - AW'(1);
   assign total_len = 16'(IP_HDR_LEN + ICMP_HDR_LEN) + 16'(len);
   assign icmp_cks = ~16'(cks_fold(sum32));
   assign ip_cks = ~16'(cks_fold(ip_sum));
   assign unused_rsvd = ^RX_ICMP_TUSER[7:0];
   assign ip_raw = 32'(IP_VS_LEN_TOS) + 32'(total_len) + 32'(user[23:8]) + 32'({user[7:0], ICMP_PROTO})
                 + 32'(FPGA_IP[31:16]) + 32'(FPGA_IP[15:0]) + 32'(dst_ip[31:16]) + 32'(dst_ip[15:0]);
   // Payload byte 0 is prefetched during CKS2 so the header-to-data handoff has no bubble.
   assign ren = state == CKS2 || (state == TX_DATA && adv && !ICMP_LAST && !data_end);
   assign raddr = state == CKS2 ? '0 : rptr + AW'(1);

   icmp_payload_buf #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_buf (
      .clk(CLK_125M),
      .we(state == LOAD && fire && !ovf),
      .waddr(len),
      .wdata(RX_ICMP_TDATA),
      .re(ren),
      .raddr(raddr),
      .rdata(rdata)
   );

   always_ff @(posedge CLK_125M) state <= SYS_RST ? IDLE : state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = RX_ICMP_TVALID ? LOAD : IDLE;
         LOAD:    state_n = !fire ? LOAD : RX_ICMP_TLAST ? (ovf ? IDLE : CKS1) : (ovf ? DROP : LOAD);
         DROP:    state_n = fire && RX_ICMP_TLAST ? IDLE : DROP;
         CKS1:    state_n = CKS2;
         CKS2:    state_n = TX_HDR;
         TX_HDR:  state_n = adv && hdr_end ? TX_DATA : TX_HDR;
         TX_DATA: state_n = ICMP_LAST && ICMP_READY ? IDLE : TX_DATA;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK_125M) begin
      if (SYS_RST) begin
         len <= '0;
         rptr <= '0;
         sum32 <= '0;
         ip_sum <= '0;
         hcnt <= '0;
         RX_ICMP_TREADY <= 1'b0;
         ICMP_DATA <= '0;
         ICMP_VALID <= 1'b0;
         ICMP_LAST <= 1'b0;
         ICMP_DROP <= 1'b0;
      end else begin
         RX_ICMP_TREADY <= state_n == LOAD || state_n == DROP;
         ICMP_DROP <= fire && RX_ICMP_TLAST && (state == DROP || (state == LOAD && ovf));
         if (state == IDLE) begin
            len <= '0;
            rptr <= '0;
            sum32 <= '0;
            hcnt <= '0;
         end
         if (state == LOAD && fire && !ovf) begin
            len <= len + AW'(1);
            sum32 <= sum32 + (len[0] ? {24'h0, RX_ICMP_TDATA} : {16'h0, RX_ICMP_TDATA, 8'h0})
                   + (first ? 32'(RX_ICMP_TUSER[63:48]) + 32'(RX_ICMP_TUSER[47:32]) : 32'h0);
            if (first) begin
               dst_mac <= PC_MAC;
               dst_ip <= PC_IP;
               user <= RX_ICMP_TUSER[63:8];
            end
         end
         if (state == CKS1) begin
            sum32 <= cks_fold(sum32);
            ip_sum <= cks_fold(ip_raw);
         end
         if (state == CKS2)
            hdr <= {dst_mac, FPGA_MAC, IP_TYPE, IP_VS_LEN_TOS, total_len, user[23:8], 16'h0000,
                    user[7:0], ICMP_PROTO, ip_cks, FPGA_IP, dst_ip,
                    ICMP_ECHO_REPLY, 8'h00, icmp_cks, user[55:40], user[39:24]};
         if (state == TX_HDR && adv) begin
            ICMP_DATA <= hdr[335:328];
            ICMP_VALID <= 1'b1;
            ICMP_LAST <= 1'b0;
            hdr <= {hdr[327:0], 8'h00};
            hcnt <= hcnt + 6'd1;
         end
         if (state == TX_DATA && ICMP_LAST && ICMP_READY) begin
            ICMP_VALID <= 1'b0;
            ICMP_LAST <= 1'b0;
         end else if (state == TX_DATA && adv) begin
            ICMP_DATA <= rdata;
            ICMP_VALID <= 1'b1;
            ICMP_LAST <= data_end;
            rptr <= rptr + AW'(1);
         end
      end
   end
endmodule

// File: tb/tb_icmp_echo_tx.sv
// tb_icmp_echo_tx: directed echo requests checked against an independent frame/checksum model.
module tb_icmp_echo_tx;
   localparam int MAX = 1472;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [47:0] pc_mac;
   logic [31:0] pc_ip;
   logic [7:0] rx_data;
   logic rx_valid, rx_tready, rx_last;
   logic [63:0] rx_user;
   logic [7:0] icmp_data;
   logic icmp_valid, icmp_last, icmp_drop;
   logic icmp_ready = 1'b1;
   logic rnd_ready = 1'b0;
   logic [47:0] src_mac = 48'h00D0_0800_0002;
   logic [31:0] src_ip = 32'hC0A8_006E;

   int total = 0, bad = 0, cyc = 0;
   int mism = 0, frames = 0, drops = 0, vcount = 0, bubbles = 0, stall_bad = 0;
   int vrise_cyc = 0, tlast_cyc = 0;
   logic [7:0] exp_q[$];
   bit exp_l[$];
   logic [7:0] cur[$];
   logic [7:0] last_frame[$];
   bit inframe = 0, prev_v = 0, prev_r = 0, prev_l = 0;
   logic [7:0] prev_d = 0;

   icmp_echo_tx dut (
      .CLK_125M(clk), .SYS_RST(rst), .PC_MAC(pc_mac), .PC_IP(pc_ip),
      .RX_ICMP_TDATA(rx_data), .RX_ICMP_TVALID(rx_valid), .RX_ICMP_TREADY(rx_tready),
      .RX_ICMP_TLAST(rx_last), .RX_ICMP_TUSER(rx_user),
      .ICMP_DATA(icmp_data), .ICMP_VALID(icmp_valid), .ICMP_READY(icmp_ready),
      .ICMP_LAST(icmp_last), .ICMP_DROP(icmp_drop)
   );

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1;
      icmp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ocsum(input logic [7:0] f[$], input int s, input int e);
      logic [31:0] a;
      a = 0;
      for (int i = s; i < e; i += 2) a += 32'({f[i], (i + 1 < e) ? f[i+1] : 8'h00});
      while (a[31:16] != 0) a = 32'(a[15:0]) + 32'(a[31:16]);
      return a[15:0];
   endfunction

   task automatic push_frame(input int n, input logic [7:0] base, input logic [7:0] step);
      logic [7:0] f[$];
      logic [15:0] c;
      logic [15:0] tl;
      tl = 16'(28 + n);
      for (int i = 5; i >= 0; i--) f.push_back(pc_mac[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) f.push_back(src_mac[i*8 +: 8]);
      f.push_back(8'h08); f.push_back(8'h00); f.push_back(8'h45); f.push_back(8'h00);
      f.push_back(tl[15:8]); f.push_back(tl[7:0]);
      f.push_back(rx_user[31:24]); f.push_back(rx_user[23:16]);
      f.push_back(8'h00); f.push_back(8'h00); f.push_back(rx_user[15:8]); f.push_back(8'h01);
      f.push_back(8'h00); f.push_back(8'h00);
      for (int i = 3; i >= 0; i--) f.push_back(src_ip[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) f.push_back(pc_ip[i*8 +: 8]);
      for (int i = 0; i < 4; i++) f.push_back(8'h00);
      for (int i = 63; i >= 32; i -= 8) f.push_back(rx_user[i -: 8]);
      for (int i = 0; i < n; i++) f.push_back(8'(base + i * step));
      c = ~ocsum(f, 14, 34);
      f[24] = c[15:8]; f[25] = c[7:0];
      c = ~ocsum(f, 34, f.size());
      f[36] = c[15:8]; f[37] = c[7:0];
      foreach (f[i]) begin
         exp_q.push_back(f[i]);
         exp_l.push_back(i == f.size() - 1);
      end
   endtask

   task automatic send(input int n, input logic [7:0] base, input logic [7:0] step);
      int i = 0, g = 0;
      logic acc;
      @(posedge clk); #1;
      rx_valid = 1;
      while (i < n && g < n + 5000) begin
         rx_data = 8'(base + i * step);
         rx_last = i == n - 1;
         @(negedge clk);
         acc = rx_tready;
         @(posedge clk); #1;
         g++;
         if (acc) begin
            if (i == n - 1) tlast_cyc = cyc;
            i++;
         end
      end
      rx_valid = 0;
      rx_last = 0;
      chk("send_done", i, n);
   endtask

   task automatic wait_frames(input int target, input string tag);
      for (int k = 0; k < 4000 && frames < target; k++) @(negedge clk);
      chk(tag, frames, target);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         cur.delete();
         inframe = 0;
         prev_v = 0;
      end else begin
         logic [7:0] d;
         bit l;
         if (prev_v && !prev_r && (icmp_valid !== 1'b1 || icmp_data !== prev_d || icmp_last !== prev_l)) stall_bad++;
         if (inframe && !icmp_valid) bubbles++;
         if (icmp_valid && !prev_v) vrise_cyc = cyc;
         if (icmp_valid) begin vcount++; inframe = 1; end
         if (icmp_drop) drops++;
         if (icmp_valid && icmp_ready) begin
            cur.push_back(icmp_data);
            if (exp_q.size() == 0) mism++;
            else begin
               d = exp_q.pop_front();
               l = exp_l.pop_front();
               if (icmp_data !== d || icmp_last !== l) mism++;
            end
            if (icmp_last) begin
               last_frame = cur;
               cur.delete();
               frames++;
               inframe = 0;
            end
         end
         prev_v = icmp_valid; prev_r = icmp_ready; prev_d = icmp_data; prev_l = icmp_last;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int m0, d0, v0, k;
      rx_valid = 0; rx_last = 0; rx_data = 0; rx_user = 0;
      pc_mac = 48'h0011_2233_4455;
      pc_ip = 32'hC0A8_0001;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", icmp_valid, 0);
      chk("rst_last", icmp_last, 0);
      chk("rst_drop", icmp_drop, 0);
      chk("rst_tready", rx_tready, 0);
      chk("rst_data", icmp_data, 0);
      @(posedge clk); #1 rst = 0;

      rx_user = 64'h0001_0007_1234_4000;
      m0 = mism;
      push_frame(32, 8'h00, 8'h01);
      send(32, 8'h00, 8'h01);
      wait_frames(1, "t1_seen");
      chk("t1_latency", vrise_cyc - tlast_cyc, 3);
      chk("t1_len", last_frame.size(), 74);
      chk("t1_bytes", mism - m0, 0);
      chk("t1_total_len", {last_frame[16], last_frame[17]}, 16'h003C);
      chk("t1_ip_cks", ocsum(last_frame, 14, 34), 16'hFFFF);
      chk("t1_icmp_cks", ocsum(last_frame, 34, last_frame.size()), 16'hFFFF);

      rx_user = 64'hBEEF_0102_0055_8000;
      pc_mac = 48'hA0B1_C2D3_E4F5;
      m0 = mism;
      push_frame(5, 8'hAA, 8'h01);
      send(5, 8'hAA, 8'h01);
      wait_frames(2, "t2_seen");
      chk("t2_len", last_frame.size(), 47);
      chk("t2_bytes", mism - m0, 0);
      chk("t2_icmp_cks", ocsum(last_frame, 34, last_frame.size()), 16'hFFFF);
      chk("t2_ip_cks", ocsum(last_frame, 14, 34), 16'hFFFF);

      rx_user = 64'h0001_0007_1234_4000;
      pc_mac = 48'h0011_2233_4455;
      m0 = mism;
      rnd_ready = 1;
      push_frame(32, 8'h00, 8'h01);
      send(32, 8'h00, 8'h01);
      wait_frames(3, "t3_seen");
      rnd_ready = 0;
      chk("t3_len", last_frame.size(), 74);
      chk("t3_bytes", mism - m0, 0);
      chk("t3_stall_stable", stall_bad, 0);

      d0 = drops; v0 = vcount;
      send(MAX + 1, 8'h11, 8'h03);
      repeat (10) @(negedge clk);
      chk("t4_drop_pulse", drops - d0, 1);
      chk("t4_no_valid", vcount - v0, 0);
      m0 = mism;
      push_frame(8, 8'h5A, 8'h07);
      send(8, 8'h5A, 8'h07);
      wait_frames(4, "t4_seen");
      chk("t4_len", last_frame.size(), 50);
      chk("t4_bytes", mism - m0, 0);

      push_frame(32, 8'h80, 8'h01);
      send(32, 8'h80, 8'h01);
      for (k = 0; k < 300 && cur.size() < 20; k++) @(negedge clk);
      chk("t5_reach_byte20", k < 300, 1);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("t5_rst_valid", icmp_valid, 0);
      chk("t5_rst_last", icmp_last, 0);
      chk("t5_rst_tready", rx_tready, 0);
      exp_q.delete();
      exp_l.delete();
      m0 = mism;
      push_frame(16, 8'h30, 8'h05);
      send(16, 8'h30, 8'h05);
      wait_frames(5, "t5_seen");
      chk("t5_len", last_frame.size(), 58);
      chk("t5_bytes", mism - m0, 0);

      m0 = mism;
      rx_user = 64'h4242_0001_0F0F_0100;
      push_frame(1, 8'h7E, 8'h00);
      send(1, 8'h7E, 8'h00);
      rx_user = 64'h1357_9BDF_2468_FF00;
      push_frame(MAX, 8'h01, 8'h01);
      send(MAX, 8'h01, 8'h01);
      wait_frames(7, "t6_seen");
      chk("t6_bytes", mism - m0, 0);
      chk("t6_len", last_frame.size(), 42 + MAX);
      chk("t6_total_len", {last_frame[16], last_frame[17]}, 16'(28 + MAX));
      chk("t6_icmp_cks", ocsum(last_frame, 34, last_frame.size()), 16'hFFFF);

      chk("no_bubbles", bubbles, 0);
      chk("exp_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
